layer_compositor_pipe: RTL and testbench

//  Parametrised N-layer successor to the fixed two-canvas paint compositor. Sits between the

---
 rtl/layer_compositor_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_layer_compositor_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor_pipe.sv
// layer_compositor_pipe
//   N-layer pixel compositor with a 3-stage pipeline and active-layer selection.
//   Visibility requests are latched only on frame_start so a frame never tears.
// Ports:
//   clk, reset_n        clock and async active-low reset
//   frame_start         1-cycle pulse at frame start; latches vis_req / cursor_vis_req
//   layer_toggle        level input; rising edge advances to the next visible layer
//   vis_req             requested per-layer visibility
//   cursor_vis_req      requested cursor visibility
//   in_valid            pixel inputs valid this cycle
//   layer_colors        packed per-layer palette indices, layer i at [i*COLOR_WIDTH +: COLOR_WIDTH]
//   cursor_color        cursor palette index
//   camera_r/g/b        background camera pixel
//   out_valid           composited pixel valid (in_valid delayed 3 cycles)
//   out_r/g/b           composited RGB, 0 when out_valid is low
//   out_source          winner: 0 camera, i+1 layer i, N_LAYERS+1 cursor
//   vis_active          latched layer visibility mask
//   active_layer        layer selected for drawing
//   active_valid        vis_active[active_layer]
//   write_enable        one-hot of active_layer when active_valid, else 0
module layer_compositor_pipe #(
    parameter int unsigned N_LAYERS    = 4,
    parameter int unsigned COLOR_WIDTH = 3,
    localparam int unsigned SRC_W      = $clog2(N_LAYERS + 2),
    localparam int unsigned AL_W       = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            frame_start,
    input  logic                            layer_toggle,
    input  logic [N_LAYERS-1:0]             vis_req,
    input  logic                            cursor_vis_req,
    input  logic                            in_valid,
    input  logic [N_LAYERS*COLOR_WIDTH-1:0] layer_colors,
    input  logic [COLOR_WIDTH-1:0]          cursor_color,
    input  logic [7:0]                      camera_r,
    input  logic [7:0]                      camera_g,
    input  logic [7:0]                      camera_b,
    output logic                            out_valid,
    output logic [7:0]                      out_r,
    output logic [7:0]                      out_g,
    output logic [7:0]                      out_b,
    output logic [SRC_W-1:0]                out_source,
    output logic [N_LAYERS-1:0]             vis_active,
    output logic [AL_W-1:0]                 active_layer,
    output logic                            active_valid,
    output logic [N_LAYERS-1:0]             write_enable
);

    // ---------------- Visibility latch and layer select ----------------
    logic            cursor_vis_q;
    logic            toggle_q;
    logic            tpulse;
    logic [AL_W-1:0] next_layer;
    logic [AL_W-1:0] cand;
    logic            found;

    assign tpulse = layer_toggle & ~toggle_q;

    // Round-robin search starting after the current layer; k = N_LAYERS revisits self.
    always_comb begin
        next_layer = active_layer;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_LAYERS; k++) begin
            cand = AL_W'((32'(active_layer) + k) % N_LAYERS);
            if (!found && vis_active[cand]) begin
                found      = 1'b1;
                next_layer = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vis_active   <= '0;
            cursor_vis_q <= 1'b0;
            toggle_q     <= 1'b0;
            active_layer <= '0;
        end else begin
            toggle_q <= layer_toggle;
            // Search uses the pre-update mask even when frame_start coincides.
            if (tpulse) begin
                active_layer <= next_layer;
            end
            if (frame_start) begin
                vis_active   <= vis_req;
                cursor_vis_q <= cursor_vis_req;
            end
        end
    end

    assign active_valid = vis_active[active_layer];
    assign write_enable = active_valid ? (N_LAYERS'(1) << active_layer) : '0;

    // ---------------- S1: capture ----------------
    logic                            s1_valid;
    logic [N_LAYERS*COLOR_WIDTH-1:0] s1_colors;
    logic [COLOR_WIDTH-1:0]          s1_cursor;
    logic [7:0]                      s1_r, s1_g, s1_b;
    logic [N_LAYERS-1:0]             s1_vis;
    logic                            s1_cvis;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_colors <= '0;
            s1_cursor <= '0;
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
            s1_vis    <= '0;
            s1_cvis   <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_colors <= layer_colors;
            s1_cursor <= cursor_color;
            s1_r      <= camera_r;
            s1_g      <= camera_g;
            s1_b      <= camera_b;
            s1_vis    <= vis_active;
            s1_cvis   <= cursor_vis_q;
        end
    end

    // ---------------- S2: priority select ----------------
    logic [SRC_W-1:0]       win_src;
    logic [COLOR_WIDTH-1:0] win_color;

    // Ascending scan so higher layers override lower ones; cursor overrides all.
    always_comb begin
        win_src   = '0;
        win_color = '0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (s1_vis[i] && (s1_colors[i*COLOR_WIDTH +: COLOR_WIDTH] != '0)) begin
                win_src   = SRC_W'(i + 1);
                win_color = s1_colors[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
        if (s1_cvis && (s1_cursor != '0)) begin
            win_src   = SRC_W'(N_LAYERS + 1);
            win_color = s1_cursor;
        end
    end

    logic                   s2_valid;
    logic [SRC_W-1:0]       s2_src;
    logic [COLOR_WIDTH-1:0] s2_color;
    logic [7:0]             s2_r, s2_g, s2_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_src   <= '0;
            s2_color <= '0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_src   <= win_src;
            s2_color <= win_color;
            s2_r     <= s1_r;
            s2_g     <= s1_g;
            s2_b     <= s1_b;
        end
    end

    // ---------------- S3: RGB mapping ----------------
    logic [7:0] map_r, map_g, map_b;

    // Only the low three index bits carry colour; higher bits are ignored.
    always_comb begin
        if (s2_src == '0) begin
            map_r = s2_r;
            map_g = s2_g;
            map_b = s2_b;
        end else begin
            map_r = {8{s2_color[2]}};
            map_g = {8{s2_color[1]}};
            map_b = {8{s2_color[0]}};
        end
    end

    logic             s3_valid;
    logic [SRC_W-1:0] s3_src;
    logic [7:0]       s3_r, s3_g, s3_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
            s3_src   <= '0;
            s3_r     <= '0;
            s3_g     <= '0;
            s3_b     <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_src   <= s2_src;
            s3_r     <= map_r;
            s3_g     <= map_g;
            s3_b     <= map_b;
        end
    end

    assign out_valid  = s3_valid;
    assign out_r      = s3_valid ? s3_r : '0;
    assign out_g      = s3_valid ? s3_g : '0;
    assign out_b      = s3_valid ? s3_b : '0;
    assign out_source = s3_valid ? s3_src : '0;

endmodule

// File: tb/tb_layer_compositor_pipe.sv
// Self-checking bench for layer_compositor_pipe (N_LAYERS=4, COLOR_WIDTH=3).
module tb_layer_compositor_pipe;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int SW = 3;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          layer_toggle = 1'b0;
    logic [N-1:0]  vis_req = '0;
    logic          cursor_vis_req = 1'b0;
    logic          in_valid = 1'b0;
    logic [N*CW-1:0] layer_colors = '0;
    logic [CW-1:0] cursor_color = '0;
    logic [7:0]    camera_r = '0, camera_g = '0, camera_b = '0;
    logic          out_valid;
    logic [7:0]    out_r, out_g, out_b;
    logic [SW-1:0] out_source;
    logic [N-1:0]  vis_active;
    logic [AW-1:0] active_layer;
    logic          active_valid;
    logic [N-1:0]  write_enable;

    layer_compositor_pipe #(.N_LAYERS(N), .COLOR_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .layer_toggle(layer_toggle),
        .vis_req(vis_req), .cursor_vis_req(cursor_vis_req), .in_valid(in_valid),
        .layer_colors(layer_colors), .cursor_color(cursor_color),
        .camera_r(camera_r), .camera_g(camera_g), .camera_b(camera_b),
        .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_source(out_source), .vis_active(vis_active), .active_layer(active_layer),
        .active_valid(active_valid), .write_enable(write_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [2:0] src;
        logic [7:0] r, g, b;
    } pix_t;

    pix_t         exp_q[$];
    logic [N-1:0] m_vis = '0;
    logic         m_cvis = 1'b0;
    logic         m_tog = 1'b0;
    int           m_al = 0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result of the pixel currently on the inputs, under the model's mask.
    function automatic pix_t model_pix(input int due);
        pix_t       p;
        logic [2:0] c;
        p.due = due;
        p.src = 3'd0;
        c     = 3'd0;
        if (m_cvis && cursor_color != 0) begin
            p.src = 3'(N + 1);
            c     = cursor_color;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (p.src == 0 && m_vis[i] && layer_colors[i*CW +: CW] != 0) begin
                    p.src = 3'(i + 1);
                    c     = layer_colors[i*CW +: CW];
                end
            end
        end
        if (p.src == 0) begin
            p.r = camera_r; p.g = camera_g; p.b = camera_b;
        end else begin
            p.r = c[2] ? 8'hFF : 8'h00;
            p.g = c[1] ? 8'hFF : 8'h00;
            p.b = c[0] ? 8'hFF : 8'h00;
        end
        return p;
    endfunction

    task automatic check_state();
        logic         av;
        logic [N-1:0] we;
        av = m_vis[m_al];
        we = av ? (N'(1) << m_al) : '0;
        chk("vis_active", 32'(vis_active), 32'(m_vis));
        chk("active_layer", 32'(active_layer), 32'(m_al));
        chk("active_valid", 32'(active_valid), 32'(av));
        chk("write_enable", 32'(write_enable), 32'(we));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            pix_t p;
            p = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_source", 32'(out_source), 32'(p.src));
            chk("out_rgb", {8'h0, out_r, out_g, out_b}, {8'h0, p.r, p.g, p.b});
        end else begin
            chk("out_idle", {4'h0, out_source, out_valid, out_r, out_g, out_b},
                32'h0);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic step();
        logic tp;
        @(posedge clk);
        if (in_valid) exp_q.push_back(model_pix(cyc + 2));
        tp    = layer_toggle && !m_tog;
        m_tog = layer_toggle;
        if (tp) begin
            for (int k = 1; k <= N; k++) begin
                if (m_vis[(m_al + k) % N]) begin
                    m_al = (m_al + k) % N;
                    break;
                end
            end
        end
        if (frame_start) begin
            m_vis  = vis_req;
            m_cvis = cursor_vis_req;
        end
        #1;
        check_state();
        cyc++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_vis  = '0;
        m_cvis = 1'b0;
        m_tog  = 1'b0;
        m_al   = 0;
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_outputs", {4'h0, out_source, out_valid, out_r, out_g, out_b}, 32'h0);
        chk("rst_state", {24'h0, vis_active, active_layer, active_valid, write_enable[0]},
            32'h0);
        chk("rst_we", 32'(write_enable), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        hold_reset();
        repeat (2) step();

        // Layer select round-robin over mask 0101.
        vis_req = 4'b0101; frame_start = 1'b1; step(); frame_start = 1'b0;
        layer_toggle = 1'b1; step(); chk("t2_al0", 32'(active_layer), 32'd2);
        chk("t2_we0", 32'(write_enable), 32'b0100);
        layer_toggle = 1'b0; step();
        layer_toggle = 1'b1; step(); chk("t2_al1", 32'(active_layer), 32'd0);
        chk("t2_we1", 32'(write_enable), 32'b0001);
        layer_toggle = 1'b0; step();
        layer_toggle = 1'b1; step(); chk("t2_al2", 32'(active_layer), 32'd2);
        chk("t2_we2", 32'(write_enable), 32'b0100);
        layer_toggle = 1'b0; step();

        // Invisible layer 3 skipped, visible layer 2 wins.
        layer_colors = {3'd5, 3'd3, 3'd0, 3'd0};
        cursor_color = 3'd0;
        camera_r = 8'h40; camera_g = 8'h40; camera_b = 8'h40;
        in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
        chk("t3_src", 32'(out_source), 32'd3);
        chk("t3_rgb", {8'h0, out_r, out_g, out_b}, 32'h0000FFFF);

        // Camera fallback, then visible cursor.
        layer_colors = '0;
        in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
        chk("t4_cam", {5'h0, out_source, out_r, out_g, out_b}, 32'h00404040);
        cursor_vis_req = 1'b1; frame_start = 1'b1; step(); frame_start = 1'b0;
        cursor_color = 3'd4;
        in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
        chk("t4_cur", {5'h0, out_source, out_r, out_g, out_b}, 32'h05FF0000);

        // Active layer latched invisible, then toggle recovers.
        vis_req = 4'b0001; frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("t5_av", {31'h0, active_valid}, 32'h0);
        chk("t5_we", 32'(write_enable), 32'h0);
        layer_toggle = 1'b1; step(); layer_toggle = 1'b0;
        chk("t5_al", 32'(active_layer), 32'd0);
        chk("t5_we2", 32'(write_enable), 32'b0001);
        step();

        // Burst with vis_req wandering but no frame_start: mask must not move.
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            vis_req = 4'($urandom);
            cursor_vis_req = 1'($urandom);
            layer_colors = 12'($urandom);
            cursor_color = 3'($urandom);
            camera_r = 8'($urandom); camera_g = 8'($urandom); camera_b = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            layer_toggle = 1'($urandom);
            vis_req = 4'($urandom);
            cursor_vis_req = 1'($urandom);
            for (int l = 0; l < N; l++)
                layer_colors[l*CW +: CW] = ($urandom_range(0, 1) != 0) ? 3'($urandom) : 3'd0;
            cursor_color = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
            camera_r = 8'($urandom); camera_g = 8'($urandom); camera_b = 8'($urandom);
            step();
        end
        frame_start = 1'b0; layer_toggle = 1'b0;

        // Reset with pixels in flight: nothing may emerge afterwards.
        in_valid = 1'b1; camera_r = 8'h11;
        repeat (3) step();
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst", {4'h0, out_source, out_valid, out_r, out_g, out_b}, 32'h0);
        hold_reset();
        repeat (5) step();
        in_valid = 1'b1; step(); in_valid = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
